// File: rtl/pcache_pkg.sv
// -----------------------------------------------------------------------------
// pcache_pkg
// Shared definitions for the direct-mapped program (instruction) cache:
//   - default geometry (LINES_DEF lines of LINE_WORDS_DEF 16-bit words)
//   - derived field widths for the default geometry
//   - FSM state encoding (IDLE, REQ, FILL, DONE)
//   - saturating increment used by the optional statistics counters
//     (built only when PCACHE_STATS_EN is defined)
// -----------------------------------------------------------------------------
package pcache_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 16;

    localparam int unsigned LINES_DEF      = 32;
    localparam int unsigned LINE_WORDS_DEF = 8;

    localparam int unsigned INDEX_W_DEF    = $clog2(LINES_DEF);
    localparam int unsigned OFFSET_W_DEF   = $clog2(LINE_WORDS_DEF);
    localparam int unsigned TAG_W_DEF      = ADDR_W - INDEX_W_DEF - OFFSET_W_DEF;

    localparam logic [31:0] STAT_MAX       = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } pcache_state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == STAT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pcache_data_ram.sv
// -----------------------------------------------------------------------------
// pcache_data_ram
// Simple dual-port data store for the program cache: one write port and one
// registered read port, DEPTH x DW. Contents are not reset.
//
// Ports:
//   clk    in   clock, all activity on rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address, sampled on the rising edge
//   rdata  out  read data, valid the cycle after raddr is sampled
//
// A read and write to the same address in one cycle returns the old data.
// -----------------------------------------------------------------------------
module pcache_data_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/p_cache.sv
// -----------------------------------------------------------------------------
// p_cache
// Direct-mapped, read-only program cache between the PC stage and an SDRAM
// controller. The PC stage presents a word address every cycle; the address is
// registered and looked up one cycle later, so instruction/p_cache_miss refer
// to the address presented in the previous accepted cycle. A miss performs a
// whole-line fill (LINE_WORDS beats, ascending order) and then replays the
// lookup so the missed word is delivered on the first IDLE cycle after DONE.
//
// Parameters:
//   LINES       number of lines (power of 2)
//   LINE_WORDS  16-bit words per line (power of 2, at least 2)
//
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   prg_address   in   word address from the PC stage
//   flush         in   invalidate all lines
//   instruction   out  fetched word
//   p_cache_miss  out  high while instruction is not valid
//   mem_req       out  line-fill request, held until mem_ack
//   mem_addr      out  line-aligned word address of the fill
//   mem_ack       in   fill request accepted
//   mem_valid     in   one fill beat on mem_data
//   mem_data      in   fill data
//   hit_count     out  (PCACHE_STATS_EN only) saturating hit counter
//   miss_count    out  (PCACHE_STATS_EN only) saturating miss counter
//
// Build option: define PCACHE_STATS_EN to add the hit/miss counters.
// -----------------------------------------------------------------------------
module p_cache
    import pcache_pkg::*;
#(
    parameter int unsigned LINES      = LINES_DEF,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] prg_address,
    input  logic        flush,
    output logic [15:0] instruction,
    output logic        p_cache_miss,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_valid,
    input  logic [15:0] mem_data
`ifdef PCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned INDEX_W  = $clog2(LINES);
    localparam int unsigned OFFSET_W = $clog2(LINE_WORDS);
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned RAM_AW   = INDEX_W + OFFSET_W;

    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

    pcache_state_e       state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic                lookup_q, lookup_d;
    logic [OFFSET_W-1:0] beat_q, beat_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic                flush_pend_q, flush_pend_d;

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q [LINES];

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag_in;
    logic                hit;
    logic                ram_we;
    logic                set_valid;

    assign idx    = addr_q[OFFSET_W +: INDEX_W];
    assign tag_in = addr_q[ADDR_W-1 -: TAG_W];
    assign hit    = valid_q[idx] && (tag_q[idx] == tag_in);

    assign p_cache_miss = (state_q == IDLE) ? ~hit : 1'b1;
    assign mem_req      = (state_q == REQ);
    assign mem_addr     = mem_addr_q;

    // lookup_q distinguishes a real lookup from the empty pipeline right after
    // reset, so the reset value of addr_q never triggers a fill.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lookup_d     = lookup_q;
        beat_d       = beat_q;
        mem_addr_d   = mem_addr_q;
        flush_pend_d = flush_pend_q;
        ram_we       = 1'b0;
        set_valid    = 1'b0;

        unique case (state_q)
            IDLE: begin
                flush_pend_d = 1'b0;
                if (lookup_q && !hit) begin
                    // Address stays frozen until the line is in place.
                    state_d    = REQ;
                    mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                end else begin
                    addr_d   = prg_address;
                    lookup_d = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = FILL;
                    beat_d  = '0;
                end
            end
            FILL: begin
                if (mem_valid) begin
                    ram_we = 1'b1;
                    beat_d = beat_q + OFFSET_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A flush seen anywhere during this fill leaves the line invalid.
                state_d   = IDLE;
                set_valid = ~(flush | flush_pend_q);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush && (state_q != IDLE)) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            lookup_q     <= 1'b0;
            beat_q       <= '0;
            mem_addr_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lookup_q     <= lookup_d;
            beat_q       <= beat_d;
            mem_addr_q   <= mem_addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Flush has priority over the DONE valid-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Tags need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (state_q == DONE) begin
            tag_q[idx] <= tag_in;
        end
    end

    // Reading at the next registered address gives 1-cycle latency; in DONE
    // addr_d equals addr_q, which re-reads the freshly filled word.
    pcache_data_ram #(
        .DEPTH (LINES * LINE_WORDS),
        .AW    (RAM_AW),
        .DW    (DATA_W)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({idx, beat_q}),
        .wdata (mem_data),
        .raddr (addr_d[RAM_AW-1:0]),
        .rdata (instruction)
    );

`ifdef PCACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;
    logic        lookup_cycle;

    assign lookup_cycle = (state_q == IDLE) && lookup_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (lookup_cycle) begin
            if (hit) begin
                hit_count_q <= sat_inc(hit_count_q);
            end else begin
                miss_count_q <= sat_inc(miss_count_q);
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_p_cache.sv
// -----------------------------------------------------------------------------
// tb_p_cache
// Self-checking bench for p_cache (default geometry 32 lines x 8 words).
// The stimulus thread drives addresses and plays the SDRAM controller; each
// time it commits to an outcome it queues the expected instruction word or
// fill address. A monitor pops and compares whenever the cache presents a
// word (p_cache_miss low) or raises mem_req. Define PCACHE_STATS_EN to also
// check the hit/miss counters.
// -----------------------------------------------------------------------------
module tb_p_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] prg_address;
    logic        flush;
    logic [15:0] instruction;
    logic        p_cache_miss;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_valid;
    logic [15:0] mem_data;
`ifdef PCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_instr [$];
    logic [31:0] exp_addr  [$];
    logic        req_prev = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [15:0] mon_word;

    p_cache dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prg_address  (prg_address),
        .flush        (flush),
        .instruction  (instruction),
        .p_cache_miss (p_cache_miss),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data)
`ifdef PCACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented word and every new fill request.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (p_cache_miss === 1'b0) begin
                if (exp_instr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%04h with p_cache_miss low, expected none (t=%0t)",
                             instruction, $time);
                end else begin
                    mon_word = exp_instr.pop_front();
                    check("instruction", {16'h0, instruction}, {16'h0, mon_word});
                end
            end
            if (mem_req === 1'b1 && !req_prev) begin
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: got mem_addr 0x%08h, expected no request (t=%0t)",
                             mem_addr, $time);
                end else begin
                    cur_addr = exp_addr.pop_front();
                    check("mem_addr", mem_addr, cur_addr);
                end
            end else if (mem_req === 1'b1) begin
                check("mem_addr_stable", mem_addr, cur_addr);
            end
            req_prev = (mem_req === 1'b1);
        end else begin
            req_prev = 1'b0;
        end
    end

    // Wait (bounded) for mem_req, ack after two held cycles, then supply beats
    // base+0..base+7 with one idle cycle before beat 4. flush is raised with
    // beat flush_beat; the task returns without driving beat stop_beat.
    task automatic serve_fill(input logic [15:0] base, input int flush_beat, input int stop_beat);
        int n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (mem_req !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL fill_request_timeout: got mem_req %b, expected 1 within 40 cycles", mem_req);
            return;
        end
        tick();
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (b == stop_beat) return;
            if (b == 4) tick();
            mem_valid = 1'b1;
            mem_data  = base + 16'(b);
            flush     = (b == flush_beat);
            tick();
            mem_valid = 1'b0;
            flush     = 1'b0;
        end
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        prg_address = 32'h0000_0010;
        flush       = 1'b0;
        mem_ack     = 1'b0;
        mem_valid   = 1'b0;
        mem_data    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_p_cache_miss", {31'h0, p_cache_miss}, 32'h1);
        check("reset_mem_req", {31'h0, mem_req}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);

        // Cold miss on 0x10, then hit stream 0x11..0x17 with stray bus activity.
        exp_addr.push_back(32'h0000_0010);
        exp_instr.push_back(16'hA000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        serve_fill(16'hA000, -1, 8);
        prg_address = 32'h0000_0011;
        mem_valid   = 1'b1;
        mem_ack     = 1'b1;
        mem_data    = 16'hFFFF;
        for (int i = 1; i < 8; i++) exp_instr.push_back(16'hA000 + 16'(i));
        tick();
        for (int i = 2; i < 8; i++) begin
            tick();
            prg_address = 32'h0000_0010 + 32'(i);
        end

        // Conflict: 0x110 maps to the same line with a different tag.
        tick();
        prg_address = 32'h0000_0110;
        mem_valid   = 1'b0;
        mem_ack     = 1'b0;
        exp_addr.push_back(32'h0000_0110);
        exp_instr.push_back(16'hB000);
        tick();
`ifdef PCACHE_STATS_EN
        @(negedge clk);
        check("hit_count", hit_count, 32'd8);
        check("miss_count", miss_count, 32'd1);
`endif
        prg_address = 32'h0000_0010;
        exp_addr.push_back(32'h0000_0010);
        exp_instr.push_back(16'hA000);
        serve_fill(16'hB000, -1, 8);
        serve_fill(16'hA000, -1, 8);
        tick();
        tick();
        rst_n = 1'b0;

        // Flush during beat 3: line stays invalid, same line requested again.
        prg_address = 32'h0000_0010;
        exp_addr.push_back(32'h0000_0010);
        exp_addr.push_back(32'h0000_0010);
        exp_instr.push_back(16'hC000);
        hold_reset();
        serve_fill(16'hD000, 3, 8);
        serve_fill(16'hC000, -1, 8);
        tick();
        tick();
        rst_n = 1'b0;

        // Reset during beat 5, stray beats afterwards must be ignored.
        exp_addr.push_back(32'h0000_0010);
        hold_reset();
        serve_fill(16'h9000, -1, 5);
        mem_valid = 1'b1;
        mem_data  = 16'h5555;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rst_mid_fill_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mid_fill_miss", {31'h0, p_cache_miss}, 32'h1);
        check("rst_mid_fill_mem_addr", mem_addr, 32'h0);
        tick();
        tick();
        exp_addr.push_back(32'h0000_0010);
        exp_instr.push_back(16'hE000);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        mem_valid = 1'b0;
        serve_fill(16'hE000, -1, 8);

        // Flush in IDLE while hitting: next lookup of the same line misses.
        tick();
        flush = 1'b1;
        exp_addr.push_back(32'h0000_0010);
        exp_instr.push_back(16'hF000);
        tick();
        flush = 1'b0;
        serve_fill(16'hF000, -1, 8);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
`ifdef PCACHE_STATS_EN
        check("reset_hit_count", hit_count, 32'd0);
        check("reset_miss_count", miss_count, 32'd0);
`endif
        check("instr_queue_drained", 32'(exp_instr.size()), 32'd0);
        check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
